etai_err_monitor: RTL
=====================

Name: etai_err_monitor

Overview:
- Parametrised, pipelined error-tolerant adder (ETA-I) with an on-chip error-metric accumulator.
- Each accepted operand pair produces the approximate sum, the exact sum and the absolute error.
- Running statistics are kept in hardware: sample count, error count, sum of absolute error and maximum absolute error.
- Sits between an operand stream source and a result sink. Replaces file-based post-processing of approximate-adder error with streaming measurement.

Parameters:
- WIDTH, 32, operand width in bits (signed two's complement); range 8..64.
- LOWER, 16, width of the inaccurate lower segment; 1 <= LOWER < WIDTH.
- CNT_W, 32, width of sample_cnt and err_cnt.
- ACC_W, 64, width of sae; must satisfy ACC_W >= WIDTH+2.

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Rst_n  in  1  synchronous, active-low reset.
- clear  in  1  synchronous clear of the statistics only; the pipeline is unaffected.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- in_a  in  WIDTH  operand A, signed.
- in_b  in  WIDTH  operand B, signed.
- in_exact  in  1  per-sample bypass: the approximate path returns the exact sum.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts the result.
- out_approx  out  WIDTH+1  approximate sum, signed.
- out_exact  out  WIDTH+1  exact sum, signed.
- out_ae  out  WIDTH+1  |out_exact - out_approx|, unsigned.
- sample_cnt  out  CNT_W  results handed off.
- err_cnt  out  CNT_W  handed-off results with out_ae != 0.
- sae  out  ACC_W  sum of out_ae over handed-off results.
- max_ae  out  WIDTH+1  maximum out_ae over handed-off results.
- sat  out  1  sticky: a counter or accumulator has saturated.

Behaviour:
- Reset (Rst_n=0 at a clock edge):
  - all valids low; in_ready=1.
  - data outputs 0; all statistics 0; sat=0.
- ETA-I arithmetic, in stage 1:
  - Upper segment: bits [WIDTH-1:LOWER] of a and b, sign-extended, added with carry-in 0, giving approx[WIDTH:LOWER].
  - Lower segment: scan i = LOWER-1 down to 0. Before the first position where a[i]&b[i]=1, s[i]=a[i]^b[i]. At that position and every position below it, s[i]=1. No carry passes into the upper segment.
  - Exact sum: sign-extended a+b, WIDTH+1 bits.
  - in_exact=1 forces approx=exact.
- AE is computed in stage 2 as a WIDTH+2-bit signed difference; its magnitude is output truncated to WIDTH+1 bits (always fits).
- Pipeline:
  - Two stages, s1 and s2; s2 is the output register.
  - Enables: s2_en = !s2_v | out_ready; s1_en = !s1_v | s2_en; in_ready = s1_en.
  - Latency: 2 cycles from in_valid&in_ready to out_valid, with no stall.
  - Throughput: 1 per cycle.
- Output handshake:
  - out_* held stable while out_valid & !out_ready.
  - No bubbles are inserted when out_ready stays high.
- Statistics update on each output handshake (out_valid & out_ready):
  - sample_cnt += 1.
  - err_cnt += (out_ae != 0).
  - sae += out_ae.
  - max_ae = max(max_ae, out_ae).
- Saturation: every counter and accumulator saturates at all-ones instead of wrapping. sat is set on any saturating update and cleared only by reset or clear.
- Simultaneous clear and handshake: the statistics take the value of that single sample (sample_cnt=1, sae=out_ae, etc.), not 0.
- Statistics outputs are registered; they reflect a handshake one cycle after it occurs.
- Reset mid-stream drops all in-flight samples; they are never counted.
- clear mid-stream does not drop samples.

Decomposition:
- Shared package etai_pkg holds:
  - the width helper functions (sum width WIDTH+1, AE width);
  - a typedef for the per-sample result record {approx, exact, ae}.
- One combinational sub-module, etai_adder_p (WIDTH, LOWER, bypass input), implements the segmented adder. It replaces the fixed 32-bit adder and is reused by other approximate-arithmetic blocks.
- Pipeline registers and statistics stay in etai_err_monitor.

Test Plan:
- Defaults, a=0x00010000, b=0x00020000, out_ready=1:
  - out_approx=out_exact=0x30000, out_ae=0, two cycles after accept;
  - sample_cnt=1, err_cnt=0.
- a=0x00008000, b=0x00008000:
  - approx=0xFFFF, exact=0x10000, ae=1.
  - Then a=3, b=1: approx=3, exact=4, ae=1.
  - After both: err_cnt=2, sae=2, max_ae=1.
- a=-1, b=1:
  - approx=-1 (0x1FFFFFFFF), exact=0, ae=1.
  - Same operands with in_exact=1: approx=0, ae=0.
- Stream 4 samples with out_ready=0 for 3 cycles:
  - in_ready drops after 2 samples are accepted;
  - out_* stays stable and sample_cnt stays 0.
  - After release, all 4 results arrive in order; sample_cnt=4.
- clear asserted on the same cycle as a handshake with ae=5:
  - next cycle sample_cnt=1, sae=5, max_ae=5, err_cnt=1.
- ACC_W=WIDTH+2, WIDTH=8, repeated max-error samples:
  - sae saturates at all-ones and sat=1;
  - a further clear returns sat=0 and all statistics to 0.

Source files
------------

// File: rtl/etai_pkg.sv
// rtl/etai_pkg.sv - shared widths and result record for the ETA-I error monitor
//
// Purpose: width helpers used by every block built around the segmented
//          approximate adder, plus the per-sample result record.
// Ports:   none (package).
package etai_pkg;

    // Signed sum of two WIDTH-bit operands
    function automatic int etai_sum_w(input int width);
        return width + 1;
    endfunction

    // |exact - approx| never exceeds the sum range, so it fits the sum width
    function automatic int etai_ae_w(input int width);
        return width + 1;
    endfunction

    // Signed difference of two sum-width values before taking the magnitude
    function automatic int etai_diff_w(input int width);
        return width + 2;
    endfunction

    localparam int ETAI_DEF_WIDTH = 32;

    // Result record at the default operand width; parametrised blocks build
    // the same layout locally from the helpers above.
    typedef struct packed {
        logic [ETAI_DEF_WIDTH:0] approx;
        logic [ETAI_DEF_WIDTH:0] exact;
        logic [ETAI_DEF_WIDTH:0] ae;
    } etai_result_t;

endpackage

// File: rtl/etai_adder_p.sv
// rtl/etai_adder_p.sv - combinational ETA-I segmented approximate adder
//
// Purpose: approximate and exact signed sums of two WIDTH-bit operands.
//          Upper segment [WIDTH-1:LOWER] is added exactly with no carry-in;
//          the lower LOWER bits use the ETA-I rule: XOR above the most
//          significant position where both bits are set, all ones from there
//          down.
// Ports:   a_i, b_i     operands (signed)
//          bypass_i     1: approx_o returns the exact sum
//          approx_o     approximate sum, WIDTH+1 bits signed
//          exact_o      exact sum, WIDTH+1 bits signed
module etai_adder_p
    import etai_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LOWER = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bypass_i,
    output logic [WIDTH:0]   approx_o,
    output logic [WIDTH:0]   exact_o
);
    localparam int UW = WIDTH - LOWER;

    logic [UW:0]      upper;
    logic [LOWER-1:0] lower;
    logic             found;

    assign upper   = {a_i[WIDTH-1], a_i[WIDTH-1:LOWER]} + {b_i[WIDTH-1], b_i[WIDTH-1:LOWER]};
    assign exact_o = {a_i[WIDTH-1], a_i} + {b_i[WIDTH-1], b_i};

    // Scan from the top of the lower segment; once a generate position is
    // seen every remaining bit saturates to one.
    always_comb begin
        found = 1'b0;
        lower = '0;
        for (int i = LOWER - 1; i >= 0; i--) begin
            if (found || (a_i[i] && b_i[i])) begin
                found    = 1'b1;
                lower[i] = 1'b1;
            end else begin
                lower[i] = a_i[i] ^ b_i[i];
            end
        end
    end

    assign approx_o = bypass_i ? exact_o : {upper, lower};

endmodule

// File: rtl/etai_err_monitor.sv
// rtl/etai_err_monitor.sv - pipelined ETA-I adder with streaming error statistics
//
// Purpose: two-stage pipeline (s1 = adder result, s2 = output register with
//          absolute error) and saturating error-metric accumulators updated
//          on every output handshake.
// Ports:   Clk, Rst_n              clock, synchronous active-low reset
//          clear                   synchronous clear of statistics only
//          in_valid/in_ready       operand handshake; in_a, in_b, in_exact
//          out_valid/out_ready     result handshake; out_approx, out_exact, out_ae
//          sample_cnt, err_cnt     handed-off results / results with nonzero error
//          sae, max_ae             sum and maximum of absolute error
//          sat                     sticky saturation flag
module etai_err_monitor
    import etai_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LOWER = 16,
    parameter int CNT_W = 32,
    parameter int ACC_W = 64
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_exact,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_approx,
    output logic [WIDTH:0]   out_exact,
    output logic [WIDTH:0]   out_ae,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [ACC_W-1:0] sae,
    output logic [WIDTH:0]   max_ae,
    output logic             sat
);
    localparam int SUM_W  = etai_sum_w(WIDTH);
    localparam int AE_W   = etai_ae_w(WIDTH);
    localparam int DIFF_W = etai_diff_w(WIDTH);

    typedef struct packed {
        logic [SUM_W-1:0] approx;
        logic [SUM_W-1:0] exact;
        logic [AE_W-1:0]  ae;
    } res_t;

    logic [SUM_W-1:0] add_approx, add_exact;
    logic [SUM_W-1:0] s1_approx_q, s1_exact_q;
    logic             s1_v_q, s2_v_q;
    logic             s1_en, s2_en, hs;
    res_t             s2_q, s2_d;
    logic signed [DIFF_W-1:0] diff;

    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d, cnt_base;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d, err_base;
    logic [ACC_W-1:0] sae_q, sae_d, sae_base;
    logic [AE_W-1:0]  max_ae_q, max_ae_d, max_base;
    logic             sat_q, sat_d;
    logic [CNT_W:0]   cnt_sum, err_sum;
    logic [ACC_W:0]   sae_sum;

    etai_adder_p #(.WIDTH(WIDTH), .LOWER(LOWER)) u_adder (
        .a_i      (in_a),
        .b_i      (in_b),
        .bypass_i (in_exact),
        .approx_o (add_approx),
        .exact_o  (add_exact)
    );

    assign s2_en    = !s2_v_q || out_ready;
    assign s1_en    = !s1_v_q || s2_en;
    assign in_ready = s1_en;
    assign hs       = s2_v_q && out_ready;

    always_comb begin
        diff        = $signed({s1_exact_q[SUM_W-1], s1_exact_q}) - $signed({s1_approx_q[SUM_W-1], s1_approx_q});
        s2_d.approx = s1_approx_q;
        s2_d.exact  = s1_exact_q;
        s2_d.ae     = diff[DIFF_W-1] ? AE_W'(-diff) : diff[AE_W-1:0];
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            s1_v_q      <= 1'b0;
            s1_approx_q <= '0;
            s1_exact_q  <= '0;
            s2_v_q      <= 1'b0;
            s2_q        <= '0;
        end else begin
            if (s1_en) begin
                s1_v_q <= in_valid;
                if (in_valid) begin
                    s1_approx_q <= add_approx;
                    s1_exact_q  <= add_exact;
                end
            end
            if (s2_en) begin
                s2_v_q <= s1_v_q;
                if (s1_v_q) begin
                    s2_q <= s2_d;
                end
            end
        end
    end

    // clear zeroes the base the handshake is applied to, so a coincident
    // handshake leaves exactly that one sample in the statistics.
    always_comb begin
        cnt_base = clear ? '0 : sample_cnt_q;
        err_base = clear ? '0 : err_cnt_q;
        sae_base = clear ? '0 : sae_q;
        max_base = clear ? '0 : max_ae_q;
        sat_d    = clear ? 1'b0 : sat_q;

        cnt_sum = {1'b0, cnt_base} + (CNT_W + 1)'(1);
        err_sum = {1'b0, err_base} + (CNT_W + 1)'(1);
        sae_sum = {1'b0, sae_base} + (ACC_W + 1)'(s2_q.ae);

        sample_cnt_d = cnt_base;
        err_cnt_d    = err_base;
        sae_d        = sae_base;
        max_ae_d     = max_base;

        if (hs) begin
            if (cnt_sum[CNT_W]) begin
                sample_cnt_d = '1;
                sat_d        = 1'b1;
            end else begin
                sample_cnt_d = cnt_sum[CNT_W-1:0];
            end
            if (s2_q.ae != '0) begin
                if (err_sum[CNT_W]) begin
                    err_cnt_d = '1;
                    sat_d     = 1'b1;
                end else begin
                    err_cnt_d = err_sum[CNT_W-1:0];
                end
            end
            if (sae_sum[ACC_W]) begin
                sae_d = '1;
                sat_d = 1'b1;
            end else begin
                sae_d = sae_sum[ACC_W-1:0];
            end
            if (s2_q.ae > max_base) begin
                max_ae_d = s2_q.ae;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            sae_q        <= '0;
            max_ae_q     <= '0;
            sat_q        <= 1'b0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            sae_q        <= sae_d;
            max_ae_q     <= max_ae_d;
            sat_q        <= sat_d;
        end
    end

    assign out_valid  = s2_v_q;
    assign out_approx = s2_q.approx;
    assign out_exact  = s2_q.exact;
    assign out_ae     = s2_q.ae;
    assign sample_cnt = sample_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign sae        = sae_q;
    assign max_ae     = max_ae_q;
    assign sat        = sat_q;

endmodule
